cic_integ_chain: RTL and testbench

CIC_INTEG_CHAIN -- requirements
Module: cic_integ_chain

---
 rtl/cic_pkg.sv | 31 +++
 rtl/cic_integrator.sv | 48 ++++
 rtl/cic_integ_chain.sv | 153 +++++++++++++++
 tb/tb_cic_integ_chain.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
// Shared constants and helpers for the CIC integrator chain.
//   CIC_WIN_DEF / CIC_N_DEF / CIC_R_DEF / CIC_WOUT_DEF : default input width,
//     stage count, interpolation ratio and output width.
//   cic_log2(v)            : exact log2 of a power-of-two ratio.
//   cic_wacc(win, n, r)    : accumulator width needed for n stages at ratio r.
// -----------------------------------------------------------------------------
package cic_pkg;

  localparam int CIC_WIN_DEF  = 16;
  localparam int CIC_N_DEF    = 3;
  localparam int CIC_R_DEF    = 8;
  localparam int CIC_WOUT_DEF = 16;

  // Largest i with 2^i <= v; for a power of two this is exactly log2(v).
  function automatic int cic_log2(input int v);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) <= v) r = i;
    end
    return r;
  endfunction

  // Each integrator stage can grow the word by log2(R) bits.
  function automatic int cic_wacc(input int win, input int n, input int r);
    return win + n * cic_log2(r);
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// -----------------------------------------------------------------------------
// cic_integrator
// One enabled integrator stage: acc <= acc + sext(din) when en is high, hold
// otherwise. The accumulator wraps modulo 2^WACC; no saturation is applied
// because the chain relies on modular arithmetic being exact end-to-end.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, clears the accumulator
//   en      : update enable (one high-rate sample)
//   din     : WIN-bit signed stage input, sign-extended to WACC bits
//   acc_out : WACC-bit registered accumulator value
// -----------------------------------------------------------------------------
module cic_integrator
  import cic_pkg::*;
#(
  parameter int WIN  = CIC_WIN_DEF,
  parameter int WACC = cic_wacc(CIC_WIN_DEF, CIC_N_DEF, CIC_R_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [WIN-1:0]  din,
  output logic [WACC-1:0] acc_out
);

  logic [WACC-1:0] acc_q;
  logic [WACC-1:0] acc_d;
  logic [WACC-1:0] din_ext;

  always_comb begin
    // Sized cast of a signed operand sign-extends.
    din_ext = WACC'($signed(din));
    acc_d   = acc_q;
    if (en) begin
      acc_d = acc_q + din_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_out = acc_q;

endmodule

// File: rtl/cic_integ_chain.sv
// -----------------------------------------------------------------------------
// cic_integ_chain
// N cascaded integrators of a CIC interpolator followed by a rounding,
// saturating output stage.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset; beats val_in and clr_sat
//   val_in   : one zero-stuffed high-rate sample per asserted cycle
//   data_in  : WIN-bit signed sample
//   clr_sat  : clears the sticky saturation flag (a same-cycle clip wins)
//   val_out  : output sample valid, two cycles after val_in
//   data_out : WOUT-bit signed output, round-half-up then clipped; 0 when idle
//   sat      : sticky flag, set whenever an output sample was clipped
//
// Handshake: valid-only streaming. A sample is transferred on every rising
// edge where val_in is high; there is no ready, the block never stalls and
// accepts a sample every cycle. val_out marks a result for exactly one cycle
// and downstream must take it on that cycle.
// -----------------------------------------------------------------------------
module cic_integ_chain
  import cic_pkg::*;
#(
  parameter int WIN  = CIC_WIN_DEF,
  parameter int N    = CIC_N_DEF,
  parameter int R    = CIC_R_DEF,
  parameter int WOUT = CIC_WOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   val_in,
  input  logic signed [WIN-1:0]  data_in,
  input  logic                   clr_sat,
  output logic                   val_out,
  output logic signed [WOUT-1:0] data_out,
  output logic                   sat
);

  localparam int WACC = cic_wacc(WIN, N, R);
  localparam int SH   = WACC - WOUT;

  // ---------------------------------------------------------------------------
  // Integrator chain. Every stage updates on the same edge and consumes the
  // previous stage's pre-edge value, so there is no ripple through the chain.
  // ---------------------------------------------------------------------------
  logic [WACC-1:0] acc [N];

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_stage
      if (k == 0) begin : g_first
        cic_integrator #(
          .WIN  (WIN),
          .WACC (WACC)
        ) u_integ (
          .clk     (clk),
          .rst     (rst),
          .en      (val_in),
          .din     (data_in),
          .acc_out (acc[0])
        );
      end else begin : g_next
        cic_integrator #(
          .WIN  (WACC),
          .WACC (WACC)
        ) u_integ (
          .clk     (clk),
          .rst     (rst),
          .en      (val_in),
          .din     (acc[k-1]),
          .acc_out (acc[k])
        );
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output scaling: round half up, arithmetic shift by SH, clip to WOUT bits.
  // ---------------------------------------------------------------------------
  logic signed [WOUT-1:0] res;
  logic                   res_clip;

  generate
    if (SH == 0) begin : g_pass
      // Full-width output: the accumulator is passed through and cannot clip.
      always_comb begin
        res      = acc[N-1];
        res_clip = 1'b0;
      end
    end else begin : g_round
      localparam logic signed [WACC:0] HALF = (WACC + 1)'(1) << (SH - 1);
      localparam logic signed [WACC:0] MAXV = {{(SH + 2){1'b0}}, {(WOUT - 1){1'b1}}};
      localparam logic signed [WACC:0] MINV = ~MAXV;

      logic signed [WACC:0] acc_ext;
      logic signed [WACC:0] rnd_sum;
      logic signed [WACC:0] scaled;

      always_comb begin
        // One guard bit so adding the rounding constant cannot wrap.
        acc_ext  = {acc[N-1][WACC-1], acc[N-1]};
        rnd_sum  = acc_ext + HALF;
        scaled   = rnd_sum >>> SH;
        res      = scaled[WOUT-1:0];
        res_clip = 1'b0;
        if (scaled > MAXV) begin
          res      = MAXV[WOUT-1:0];
          res_clip = 1'b1;
        end else if (scaled < MINV) begin
          res      = MINV[WOUT-1:0];
          res_clip = 1'b1;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Valid pipeline and output registers. v1 marks the cycle in which the last
  // accumulator holds the freshly integrated sample.
  // ---------------------------------------------------------------------------
  logic                   v1_q,       v1_d;
  logic                   val_out_q,  val_out_d;
  logic signed [WOUT-1:0] data_out_q, data_out_d;
  logic                   sat_q,      sat_d;

  always_comb begin
    v1_d       = val_in;
    val_out_d  = v1_q;
    data_out_d = '0;
    if (v1_q) begin
      data_out_d = res;
    end
    // A new clip sets the flag even when a clear arrives on the same edge.
    sat_d = (v1_q & res_clip) | (sat_q & ~clr_sat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      val_out_q  <= 1'b0;
      data_out_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      v1_q       <= v1_d;
      val_out_q  <= val_out_d;
      data_out_q <= data_out_d;
      sat_q      <= sat_d;
    end
  end

  assign val_out  = val_out_q;
  assign data_out = data_out_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_cic_integ_chain.sv
// -----------------------------------------------------------------------------
// tb_cic_integ_chain
// Four configurations of cic_integ_chain share clk/rst/data_in/clr_sat; only
// the selected one sees val_in. The reference model recomputes the last
// integrator from the whole sample history with binomial weights
// (acc_k(t) = sum_i x_i * C(t-i, k)), wraps, rounds and clips with plain
// 64-bit arithmetic. Expected {sat, data} pairs go into exp_q; a negedge
// monitor pops them whenever the selected DUT presents val_out.
// -----------------------------------------------------------------------------
module tb_cic_integ_chain;

  localparam int EXP_W = 65;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst     = 1'b1;
  logic               val_in  = 1'b0;
  logic signed [15:0] data_in = '0;
  logic               clr_sat = 1'b0;
  int                 sel     = 0;

  // ----------------------------------------------------------------- DUTs
  logic               vo0, vo1, vo2, vo3;
  logic signed [15:0] do0;
  logic signed [16:0] do1;
  logic signed [4:0]  do2;
  logic signed [15:0] do3;
  logic               sat0, sat1, sat2, sat3;

  cic_integ_chain u_def (
    .clk (clk), .rst (rst), .val_in (val_in && sel == 0), .data_in (data_in),
    .clr_sat (clr_sat), .val_out (vo0), .data_out (do0), .sat (sat0)
  );

  cic_integ_chain #(.WIN(16), .N(1), .R(2), .WOUT(17)) u_step (
    .clk (clk), .rst (rst), .val_in (val_in && sel == 1), .data_in (data_in),
    .clr_sat (clr_sat), .val_out (vo1), .data_out (do1), .sat (sat1)
  );

  cic_integ_chain #(.WIN(4), .N(1), .R(2), .WOUT(5)) u_wrap (
    .clk (clk), .rst (rst), .val_in (val_in && sel == 2), .data_in (data_in[3:0]),
    .clr_sat (clr_sat), .val_out (vo2), .data_out (do2), .sat (sat2)
  );

  cic_integ_chain #(.WIN(16), .N(1), .R(512), .WOUT(16)) u_sat (
    .clk (clk), .rst (rst), .val_in (val_in && sel == 3), .data_in (data_in),
    .clr_sat (clr_sat), .val_out (vo3), .data_out (do3), .sat (sat3)
  );

  // Per-configuration constants derived independently: WACC = WIN + N*log2(R).
  int n_t    [4] = '{3, 1, 1, 1};
  int wacc_t [4] = '{25, 17, 5, 25};
  int wout_t [4] = '{16, 17, 5, 16};

  logic   mon_val;
  longint mon_data;
  logic   mon_sat;

  always_comb begin
    mon_val  = vo0;
    mon_data = longint'(do0);
    mon_sat  = sat0;
    case (sel)
      1: begin mon_val = vo1; mon_data = longint'(do1); mon_sat = sat1; end
      2: begin mon_val = vo2; mon_data = longint'(do2); mon_sat = sat2; end
      3: begin mon_val = vo3; mon_data = longint'(do3); mon_sat = sat3; end
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- scoreboard
  logic [EXP_W-1:0] exp_q[$];
  longint           hist[$];
  longint           obs_q[$];
  bit               obs_sat_q[$];
  int               checks = 0;
  int               errors = 0;
  int               pulses = 0;
  bit               mon_en = 1'b0;
  bit               sat_exp = 1'b0;
  bit               pend_v = 1'b0;
  bit               pend_clip = 1'b0;
  longint           pend_data = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint binom(input longint n, input int k);
    longint c;
    if (n < k) return 0;
    c = 1;
    for (int j = 0; j < k; j++) c = c * (n - j) / (j + 1);
    return c;
  endfunction

  // Output of the selected configuration after the newest sample in hist.
  function automatic void model_out(output longint val, output bit clip);
    longint acc, m, modv, r, hi, lo;
    int     t, sh;
    t   = hist.size();
    acc = 0;
    for (int i = 0; i < t; i++) acc += hist[i] * binom(t - 1 - i, n_t[sel] - 1);
    modv = longint'(1) << wacc_t[sel];
    m    = acc & (modv - 1);
    if (m >= modv / 2) m -= modv;
    sh   = wacc_t[sel] - wout_t[sel];
    clip = 1'b0;
    if (sh == 0) begin
      val = m;
    end else begin
      r  = (m + (longint'(1) << (sh - 1))) >>> sh;
      hi = (longint'(1) << (wout_t[sel] - 1)) - 1;
      lo = -(longint'(1) << (wout_t[sel] - 1));
      val = r;
      if (r > hi) begin val = hi; clip = 1'b1; end
      if (r < lo) begin val = lo; clip = 1'b1; end
    end
  endfunction

  // ----------------------------------------------------------------- driver
  // One cycle of stimulus; the model advances right after the edge. The
  // result of a sample is pushed one cycle later, on the edge that loads the
  // output register, together with the sat value that edge produces.
  task automatic drive(input bit r, input bit v, input longint d, input bit c);
    longint val;
    bit     clip;
    rst     = r;
    val_in  = v;
    data_in = 16'(d);
    clr_sat = c;
    @(posedge clk);
    #1;
    if (r) begin
      hist.delete();
      pend_v  = 1'b0;
      sat_exp = 1'b0;
    end else begin
      sat_exp = (pend_v && pend_clip) || (sat_exp && !c);
      if (pend_v) exp_q.push_back({sat_exp, pend_data});
      pend_v = 1'b0;
      if (v) begin
        hist.push_back(d);
        model_out(val, clip);
        pend_data = val;
        pend_clip = clip;
        pend_v    = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 1'b0);
  endtask

  // Reset everything, then switch the observed configuration.
  task automatic start_phase(input int s);
    drive(1'b1, 1'b0, 0, 1'b0);
    sel = s;
    obs_q.delete();
    obs_sat_q.delete();
    pulses = 0;
  endtask

  // ----------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (mon_en) begin
      logic [EXP_W-1:0] e;
      if (mon_val) begin
        pulses++;
        obs_q.push_back(mon_data);
        obs_sat_q.push_back(mon_sat);
      end
      if (mon_val && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data_out", mon_data, $signed(e[63:0]));
        check("sat_with_out", longint'(mon_sat), longint'(e[64]));
      end else if (mon_val) begin
        checks++;
        errors++;
        $display("FAIL unexpected_val_out: got val_out=1 data=%0d, expected no output", mon_data);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_val_out: got val_out=0, expected data=%0d", $signed(e[63:0]));
      end else begin
        check("idle_data_zero", mon_data, 0);
      end
      check("sat_flag", longint'(mon_sat), longint'(sat_exp));
    end
  end

  // ----------------------------------------------------------------- stimulus
  initial begin
    logic signed [15:0] rnd16;
    bit                 rv, rc, rr;

    drive(1'b1, 1'b0, 0, 1'b0);
    mon_en = 1'b1;
    drive(1'b1, 1'b0, 0, 1'b0);
    check("reset_val_out", longint'(vo0), 0);

    // Step: N=1, R=2, full-width output.
    start_phase(1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 5, 1'b0);
    idle(3);
    check("step_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check("step_0", obs_q[0], 5);
      check("step_1", obs_q[1], 10);
      check("step_2", obs_q[2], 15);
      check("step_3", obs_q[3], 20);
    end

    // Wrap: WACC=5, 21 wraps to -11.
    start_phase(2);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 7, 1'b0);
    idle(3);
    check("wrap_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("wrap_0", obs_q[0], 7);
      check("wrap_1", obs_q[1], 14);
      check("wrap_2", obs_q[2], -11);
    end

    // Saturation: R=512, SH=9; the 513th sample rounds to 32768 and clips.
    start_phase(3);
    for (int i = 0; i < 512; i++) drive(1'b0, 1'b1, 32767, 1'b0);
    drive(1'b0, 1'b1, 511, 1'b0);
    idle(2);
    check("sat_count", obs_q.size(), 513);
    if (obs_q.size() == 513) begin
      check("sat_prev_data", obs_q[511], 32767);
      check("sat_prev_flag", longint'(obs_sat_q[511]), 0);
      check("sat_last_data", obs_q[512], 32767);
      check("sat_last_flag", longint'(obs_sat_q[512]), 1);
    end
    // A zero sample keeps the accumulator at its max, clipping again on the
    // same edge as clr_sat: the set wins. Then clr_sat alone clears.
    drive(1'b0, 1'b1, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b1);
    check("clr_with_clip", longint'(sat3), 1);
    drive(1'b0, 1'b0, 0, 1'b1);
    check("clr_alone", longint'(sat3), 0);
    idle(2);

    // Gating on the default configuration.
    start_phase(0);
    drive(1'b0, 1'b1, 100, 1'b0);
    drive(1'b0, 1'b0, 999, 1'b0);
    drive(1'b0, 1'b0, 999, 1'b0);
    drive(1'b0, 1'b1, 100, 1'b0);
    idle(3);
    check("gate_pulses", pulses, 2);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 30000, 1'b0);
    idle(3);

    // Reset during a continuous stream discards in-flight samples.
    start_phase(0);
    for (int i = 0; i < 10; i++) begin
      rnd16 = 16'($urandom());
      drive(1'b0, 1'b1, longint'(rnd16), 1'b0);
    end
    drive(1'b1, 1'b1, 12345, 1'b1);
    check("rst_val_out", longint'(vo0), 0);
    check("rst_data_out", longint'(do0), 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 20000 - i * 3000, 1'b0);
    idle(3);
    check("post_rst_pulses", pulses, 10);

    // Random traffic on the default configuration.
    start_phase(0);
    for (int i = 0; i < 300; i++) begin
      rnd16 = 16'($urandom());
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 15) == 0);
      rr = ($urandom_range(0, 99) == 0);
      drive(rr, rv, longint'(rnd16), rc);
    end
    idle(3);

    // Random traffic on the narrow wrapping configuration.
    start_phase(2);
    for (int i = 0; i < 60; i++) begin
      rv = ($urandom_range(0, 2) != 0);
      drive(1'b0, rv, longint'(int'($urandom_range(0, 15)) - 8), 1'b0);
    end
    idle(3);

    check("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
